// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core: Tuse/Tnew and MDU hazard
// detection, flush handling, MDU busy tracking and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  rs_tuse_D,
    input  logic [1:0]  rt_tuse_D,
    input  logic [4:0]  wreg_E,
    input  logic [1:0]  tnew_E,
    input  logic [4:0]  wreg_M,
    input  logic [1:0]  tnew_M,
    input  logic        md_start_E,
    input  logic        md_is_div_E,
    input  logic        md_use_D,
    input  logic        flush_req,
    output logic        PC_En,
    output logic        PR_IF_ID_En,
    output logic        PR_IF_ID_Clr,
    output logic        PR_ID_EX_Clr,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    typedef enum logic {IDLE, BUSY} md_state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    md_state_t  state, state_next;
    logic [3:0] md_cnt, md_cnt_next;
    logic       hz_rs, hz_rt, hz_md, stall;

    // A source stalls only if a producer's result is still further away than the consumer's need.
    function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                        input logic [4:0] we, input logic [1:0] te,
                                        input logic [4:0] wm, input logic [1:0] tm);
        return (tuse != 2'd3) && (src != 5'd0) &&
               (((src == we) && (te > tuse)) || ((src == wm) && (tm > tuse)));
    endfunction

    assign hz_rs   = src_hazard(rs_D, rs_tuse_D, wreg_E, tnew_E, wreg_M, tnew_M);
    assign hz_rt   = src_hazard(rt_D, rt_tuse_D, wreg_E, tnew_E, wreg_M, tnew_M);
    assign md_busy = (state == BUSY);
    assign hz_md   = md_use_D && (md_busy || md_start_E);
    assign stall   = (hz_rs || hz_rt || hz_md) && !flush_req;

    always_comb begin
        PC_En        = 1'b1;
        PR_IF_ID_En  = 1'b1;
        PR_IF_ID_Clr = 1'b0;
        PR_ID_EX_Clr = 1'b0;
        if (flush_req) begin
            PR_IF_ID_Clr = 1'b1;
            PR_ID_EX_Clr = 1'b1;
        end else if (stall) begin
            PC_En        = 1'b0;
            PR_IF_ID_En  = 1'b0;
            PR_ID_EX_Clr = 1'b1;
        end
    end

    // A new issue while still busy (only possible after a flush) restarts the window.
    always_comb begin
        state_next  = state;
        md_cnt_next = md_cnt;
        case (state)
            IDLE: begin
                if (md_start_E) begin
                    md_cnt_next = md_is_div_E ? DIV_LOAD : MULT_LOAD;
                    state_next  = BUSY;
                end
            end
            BUSY: begin
                if (md_start_E) begin
                    md_cnt_next = md_is_div_E ? DIV_LOAD : MULT_LOAD;
                end else begin
                    md_cnt_next = md_cnt - 4'd1;
                    if (md_cnt == 4'd1) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next  = IDLE;
                md_cnt_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            md_cnt <= 4'd0;
        end else begin
            state  <= state_next;
            md_cnt <= md_cnt_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: a cycle model pushes expected outputs to a scoreboard
// queue as each stimulus is applied; each scenario pops and compares them.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  rs_D, rt_D, wreg_E, wreg_M;
    logic [1:0]  rs_tuse_D, rt_tuse_D, tnew_E, tnew_M;
    logic        md_start_E, md_is_div_E, md_use_D, flush_req;
    logic        PC_En, PR_IF_ID_En, PR_IF_ID_Clr, PR_ID_EX_Clr, md_busy;
    logic [31:0] stall_cnt;

    int          tests = 0;
    int          fails = 0;
    int          m_rem = 0;
    logic [31:0] m_cnt = 32'd0;
    logic [36:0] sbq[$];
    logic [36:0] got, exp;

    hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst(rst),
        .rs_D(rs_D), .rt_D(rt_D), .rs_tuse_D(rs_tuse_D), .rt_tuse_D(rt_tuse_D),
        .wreg_E(wreg_E), .tnew_E(tnew_E), .wreg_M(wreg_M), .tnew_M(tnew_M),
        .md_start_E(md_start_E), .md_is_div_E(md_is_div_E), .md_use_D(md_use_D),
        .flush_req(flush_req),
        .PC_En(PC_En), .PR_IF_ID_En(PR_IF_ID_En), .PR_IF_ID_Clr(PR_IF_ID_Clr),
        .PR_ID_EX_Clr(PR_ID_EX_Clr), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic hz_src(input logic [4:0] r, input logic [1:0] tu);
        if (tu == 2'd3 || r == 5'd0) return 1'b0;
        if (r == wreg_E && tnew_E > tu) return 1'b1;
        if (r == wreg_M && tnew_M > tu) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_stall();
        logic busy;
        busy = (m_rem > 0) && !rst;
        if (flush_req) return 1'b0;
        return hz_src(rs_D, rs_tuse_D) || hz_src(rt_D, rt_tuse_D) ||
               (md_use_D && (busy || md_start_E));
    endfunction

    function automatic logic [36:0] model_out();
        logic [3:0] ctl;
        if (flush_req)      ctl = 4'b1111;
        else if (m_stall()) ctl = 4'b0001;
        else                ctl = 4'b1100;
        return {ctl, (m_rem > 0), m_cnt};
    endfunction

    function automatic logic [36:0] dut_out();
        return {PC_En, PR_IF_ID_En, PR_IF_ID_Clr, PR_ID_EX_Clr, md_busy, stall_cnt};
    endfunction

    task automatic idle_inputs();
        rs_D = 5'd0; rt_D = 5'd0; rs_tuse_D = 2'd3; rt_tuse_D = 2'd3;
        wreg_E = 5'd0; tnew_E = 2'd0; wreg_M = 5'd0; tnew_M = 2'd0;
        md_start_E = 1'b0; md_is_div_E = 1'b0; md_use_D = 1'b0; flush_req = 1'b0;
    endtask

    task automatic apply_hz(input int rs, input int rt, input int rsu, input int rtu,
                            input int we, input int te, input int wm, input int tm);
        rs_D = 5'(rs); rt_D = 5'(rt); rs_tuse_D = 2'(rsu); rt_tuse_D = 2'(rtu);
        wreg_E = 5'(we); tnew_E = 2'(te); wreg_M = 5'(wm); tnew_M = 2'(tm);
    endtask

    task automatic settle();
        #1;
        sbq.push_back(model_out());
    endtask

    // Advance one clock edge, update the model with the inputs seen at that edge.
    task automatic next_cycle();
        logic s;
        @(posedge clk);
        if (rst) begin
            m_rem = 0;
            m_cnt = 32'd0;
        end else begin
            s = m_stall();
            if (s && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (md_start_E) m_rem = md_is_div_E ? 10 : 5;
            else if (m_rem > 0) m_rem = m_rem - 1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 rst = 1'b1;
        @(negedge clk);
        settle();
        got = dut_out(); exp = sbq.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL reset_idle: got %h expected %h", got, exp); end
        apply_hz(8, 0, 1, 3, 8, 2, 0, 0);
        settle();
        got = dut_out(); exp = sbq.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL reset_comb: got %h expected %h", got, exp); end
        next_cycle();
        settle();
        got = dut_out(); exp = sbq.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL reset_hold: got %h expected %h", got, exp); end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_data_hazard();
        int c [5][8];
        c[0] = '{8, 0, 1, 3, 8, 2, 0, 0};
        c[1] = '{0, 9, 3, 1, 0, 0, 9, 2};
        c[2] = '{8, 0, 1, 3, 8, 1, 0, 0};
        c[3] = '{5, 6, 0, 0, 7, 2, 6, 1};
        c[4] = '{3, 3, 3, 3, 3, 2, 3, 2};
        for (int i = 0; i < 5; i++) begin
            apply_hz(c[i][0], c[i][1], c[i][2], c[i][3], c[i][4], c[i][5], c[i][6], c[i][7]);
            settle();
            got = dut_out(); exp = sbq.pop_front(); tests++;
            if (got !== exp) begin fails++; $display("FAIL data_hazard[%0d]: got %h expected %h", i, got, exp); end
            next_cycle();
            idle_inputs();
            settle();
            got = dut_out(); exp = sbq.pop_front(); tests++;
            if (got !== exp) begin fails++; $display("FAIL data_hazard_after[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_forward();
        int c [3][8];
        c[0] = '{8, 0, 0, 3, 0, 0, 8, 0};
        c[1] = '{0, 0, 1, 3, 0, 2, 0, 0};
        c[2] = '{0, 0, 0, 0, 0, 2, 0, 2};
        for (int i = 0; i < 3; i++) begin
            apply_hz(c[i][0], c[i][1], c[i][2], c[i][3], c[i][4], c[i][5], c[i][6], c[i][7]);
            settle();
            got = dut_out(); exp = sbq.pop_front(); tests++;
            if (got !== exp) begin fails++; $display("FAIL forward[%0d]: got %h expected %h", i, got, exp); end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_div_mflo();
        idle_inputs();
        md_use_D = 1'b1;
        md_start_E = 1'b1;
        md_is_div_E = 1'b1;
        for (int i = 0; i < 13; i++) begin
            settle();
            got = dut_out(); exp = sbq.pop_front(); tests++;
            if (got !== exp) begin fails++; $display("FAIL div_mflo[%0d]: got %h expected %h", i, got, exp); end
            next_cycle();
            md_start_E = 1'b0;
            md_is_div_E = 1'b0;
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        apply_hz(8, 0, 1, 3, 8, 2, 0, 0);
        flush_req = 1'b1;
        settle();
        got = dut_out(); exp = sbq.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL flush_over_stall: got %h expected %h", got, exp); end
        next_cycle();
        idle_inputs();
        settle();
        got = dut_out(); exp = sbq.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL flush_cnt_hold: got %h expected %h", got, exp); end
        // div in flight, then a flush carrying a new mult reloads the busy window
        md_start_E = 1'b1;
        md_is_div_E = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin flush_req = 1'b1; md_start_E = 1'b1; md_is_div_E = 1'b0; end
            settle();
            got = dut_out(); exp = sbq.pop_front(); tests++;
            if (got !== exp) begin fails++; $display("FAIL flush_reload[%0d]: got %h expected %h", i, got, exp); end
            next_cycle();
            idle_inputs();
        end
    endtask

    task automatic test_reset_mid_mult();
        idle_inputs();
        md_use_D = 1'b1;
        md_start_E = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            got = dut_out(); exp = sbq.pop_front(); tests++;
            if (got !== exp) begin fails++; $display("FAIL mid_mult_pre[%0d]: got %h expected %h", i, got, exp); end
            if (i < 3) next_cycle();
            md_start_E = 1'b0;
        end
        #2 rst = 1'b1;
        m_rem = 0;
        m_cnt = 32'd0;
        settle();
        got = dut_out(); exp = sbq.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL mid_mult_async: got %h expected %h", got, exp); end
        tests++;
        if (md_busy !== 1'b0 || stall_cnt !== 32'd0) begin
            fails++; $display("FAIL mid_mult_clear: got busy=%b cnt=%h expected busy=0 cnt=0", md_busy, stall_cnt);
        end
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        md_start_E = 1'b1;
        for (int i = 0; i < 8; i++) begin
            settle();
            got = dut_out(); exp = sbq.pop_front(); tests++;
            if (got !== exp) begin fails++; $display("FAIL mid_mult_post[%0d]: got %h expected %h", i, got, exp); end
            next_cycle();
            md_start_E = 1'b0;
        end
    endtask

    task automatic test_saturation();
        idle_inputs();
        force dut.stall_cnt = 32'hFFFF_FFFE;
        m_cnt = 32'hFFFF_FFFE;
        #1 release dut.stall_cnt;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) apply_hz(8, 0, 1, 3, 8, 2, 0, 0);
            else idle_inputs();
            settle();
            got = dut_out(); exp = sbq.pop_front(); tests++;
            if (got !== exp) begin fails++; $display("FAIL saturation[%0d]: got %h expected %h", i, got, exp); end
            next_cycle();
        end
        settle();
        got = dut_out(); exp = sbq.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL saturation_final: got %h expected %h", got, exp); end
        tests++;
        if (stall_cnt !== 32'hFFFF_FFFF) begin
            fails++; $display("FAIL saturation_value: got %h expected ffffffff", stall_cnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_data_hazard();
        test_forward();
        test_div_mflo();
        test_flush();
        test_reset_mid_mult();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Drives the enable and clear of the IF/ID register, the PC enable, and the ID/EX bubble insert.
- Detects load-use and Tuse/Tnew data hazards against the E and M stages.
- Tracks the multi-cycle multiply/divide unit (MDU) with a busy counter and stalls HI/LO users.
- Handles exception/eret flush requests and keeps a saturating stall-cycle performance counter.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu issue.
- DIV_CYCLES, 10, busy cycles after a div/divu issue.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- rs_D  in  5  rs field of the instruction in D.
- rt_D  in  5  rt field of the instruction in D.
- rs_tuse_D  in  2  cycles until rs is needed (0..2); 3 means rs is not read.
- rt_tuse_D  in  2  same encoding, for rt.
- wreg_E  in  5  destination register of the instruction in E; 0 means none.
- tnew_E  in  2  cycles until the E result is forwardable.
- wreg_M  in  5  destination register of the instruction in M; 0 means none.
- tnew_M  in  2  cycles until the M result is forwardable.
- md_start_E  in  1  mult/div issued in E this cycle.
- md_is_div_E  in  1  1 = div/divu, 0 = mult/multu; qualified by md_start_E.
- md_use_D  in  1  instruction in D is mult/div/mfhi/mflo/mthi/mtlo.
- flush_req  in  1  exception or eret; kill instructions in F and D.
- PC_En  out  1  PC register write enable.
- PR_IF_ID_En  out  1  IF/ID register enable.
- PR_IF_ID_Clr  out  1  IF/ID register synchronous clear.
- PR_ID_EX_Clr  out  1  ID/EX clear (inserts a bubble).
- md_busy  out  1  MDU busy, registered.
- stall_cnt  out  32  stall cycles since reset, saturating.

Behaviour:
- Data hazard, combinational:
  - hz_rs = rs_tuse_D!=3 && rs_D!=0 && ((rs_D==wreg_E && tnew_E>rs_tuse_D) || (rs_D==wreg_M && tnew_M>rs_tuse_D)).
  - hz_rt is the same expression using rt_D and rt_tuse_D.
- MDU hazard, combinational: hz_md = md_use_D && (md_busy || md_start_E).
- stall = (hz_rs || hz_rt || hz_md) && !flush_req.
- Output priority:
  - flush_req=1: PC_En=1, PR_IF_ID_En=1, PR_IF_ID_Clr=1, PR_ID_EX_Clr=1.
  - else stall=1: PC_En=0, PR_IF_ID_En=0, PR_IF_ID_Clr=0, PR_ID_EX_Clr=1.
  - else: PC_En=1, PR_IF_ID_En=1, both clears 0.
- All control outputs are combinational with zero latency and take effect at the same clock edge.
- MDU FSM with states IDLE and BUSY, and a 4-bit down-counter md_cnt:
  - IDLE, md_start_E=1: load md_cnt = (md_is_div_E ? DIV_CYCLES : MULT_CYCLES), go to BUSY.
  - BUSY: md_cnt decrements each cycle. When md_cnt==1 the next state is IDLE.
  - md_busy = (state==BUSY).
  - A mult issued at edge k sees md_busy=1 for cycles k+1 .. k+MULT_CYCLES, then 0.
  - BUSY with md_start_E=1 (only reachable after a flush): reload the counter with the new count; the latest issue wins.
  - flush_req does not abort the MDU; an issued mult/div always completes.
- stall_cnt increments on each rising edge where stall=1; it holds at 32'hFFFF_FFFF.
- Asynchronous reset, rst=1:
  - state=IDLE, md_cnt=0, md_busy=0, stall_cnt=0, immediately and independent of clk.
  - Combinational outputs follow their inputs, with md_busy forced to 0.
  - A reset that arrives mid-BUSY drops md_busy in the same cycle.
- Register $0 never causes a hazard. A hazard where tnew equals tuse is resolved by forwarding, not by a stall.

Test Plan:
- Load-use: wreg_E=8, tnew_E=2, rs_D=8, rs_tuse_D=1 -> PC_En=0, PR_IF_ID_En=0, PR_ID_EX_Clr=1; stall_cnt 0->1 at the edge.
- Forwardable: wreg_M=8, tnew_M=0, rs_D=8, rs_tuse_D=0 -> no stall. Also rs_D=0 with wreg_E=0, tnew_E=2 -> no stall.
- Div then mflo:
  - md_start_E=1, md_is_div_E=1 at edge 0 -> md_busy=1 for exactly 10 cycles.
  - md_use_D=1 held throughout -> stall on the issue cycle and all 10 busy cycles, released at cycle 11.
- Flush overrides stall: hz_rs active and flush_req=1 -> PR_IF_ID_Clr=1, PR_ID_EX_Clr=1, PC_En=1; stall_cnt unchanged.
- Reset mid-mult: assert rst asynchronously at busy cycle 3 -> md_busy=0 and stall_cnt=0 before the next edge. After release, a new mult gives 5 busy cycles.
- Saturation: preload the counter via force to 32'hFFFF_FFFE, apply 3 stall cycles -> stall_cnt=32'hFFFF_FFFF.
